solitaire_move_ctrl: RTL and testbench

Move sequencer between the user pins and the peg-solitaire board datapath. It synchronises and edge-detects a raw "go" button and captures the user's move (x, y, direction). It issues that move to the board over a valid/ready handshake, then waits for the board's verdict. It reports the result, keeps a count of legal moves, and blocks moves once the board signals game over.

---
 rtl/solitaire_move_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_solitaire_move_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/solitaire_move_ctrl.sv
// solitaire_move_ctrl: takes one user move per "go" press and hands it to the
// board datapath over a valid/ready handshake. It waits for the board's
// verdict or a timeout, reports the result, and keeps a saturating count of
// legal moves. Moves are refused while the board signals game over.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a synchronised go edge
// ISSUE  | mv_valid high, captured move held until the board accepts it
// WAIT   | request accepted, waiting for mv_done (or timeout)
// REPORT | one-cycle status_pulse; last_ok/last_err/move_count updated

module solitaire_move_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 15,
    parameter int MOVE_CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go_in,
    input  logic [2:0]            piece_x,
    input  logic [2:0]            piece_y,
    input  logic [1:0]            direction,
    input  logic                  game_over,
    output logic                  mv_valid,
    output logic [2:0]            mv_x,
    output logic [2:0]            mv_y,
    output logic [1:0]            mv_dir,
    input  logic                  mv_ready,
    input  logic                  mv_done,
    input  logic                  mv_legal,
    output logic                  busy,
    output logic                  status_pulse,
    output logic                  last_ok,
    output logic [1:0]            last_err,
    output logic [MOVE_CNT_W-1:0] move_count
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    // The timer counts down from TIMEOUT-1, so zero marks the TIMEOUT-th
    // cycle spent in ISSUE+WAIT.
    localparam logic [TMR_W-1:0] TIMER_LOAD = TMR_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_BLOCKED = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   go_prev;
    logic                   go_rise;
    logic [TMR_W-1:0]       timer;
    logic                   timer_zero;

    logic                   capture;
    logic                   rpt_load;
    logic                   rpt_ok;
    logic [1:0]             rpt_err;
    logic                   count_inc;

    // Go synchroniser and edge detector. The chain resets to ones so that a
    // button held through reset does not look like a fresh press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '1;
            go_prev <= 1'b1;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], go_in};
            go_prev <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign go_rise    = sync_ff[SYNC_STAGES-1] & ~go_prev;
    assign timer_zero = (timer == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; completion events are checked before timeout.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        rpt_load   = 1'b0;
        rpt_ok     = 1'b0;
        rpt_err    = ERR_NONE;
        count_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (go_rise) begin
                    if (game_over) begin
                        state_next = REPORT;
                        rpt_load   = 1'b1;
                        rpt_err    = ERR_BLOCKED;
                    end else begin
                        state_next = ISSUE;
                        capture    = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (mv_ready) begin
                    state_next = WAIT;
                end else if (timer_zero) begin
                    state_next = REPORT;
                    rpt_load   = 1'b1;
                    rpt_err    = ERR_TIMEOUT;
                end
            end
            WAIT: begin
                if (mv_done) begin
                    state_next = REPORT;
                    rpt_load   = 1'b1;
                    if (mv_legal) begin
                        rpt_ok    = 1'b1;
                        count_inc = 1'b1;
                    end else begin
                        rpt_err = ERR_ILLEGAL;
                    end
                end else if (timer_zero) begin
                    state_next = REPORT;
                    rpt_load   = 1'b1;
                    rpt_err    = ERR_TIMEOUT;
                end
            end
            REPORT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Move capture and the ISSUE+WAIT timeout down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mv_x   <= '0;
            mv_y   <= '0;
            mv_dir <= '0;
            timer  <= '0;
        end else if (capture) begin
            mv_x   <= piece_x;
            mv_y   <= piece_y;
            mv_dir <= direction;
            timer  <= TIMER_LOAD;
        end else if ((state == ISSUE || state == WAIT) && !timer_zero) begin
            timer <= timer - TMR_W'(1);
        end
    end

    // Result registers, loaded on the edge that enters REPORT.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ok    <= 1'b0;
            last_err   <= ERR_NONE;
            move_count <= '0;
        end else begin
            if (rpt_load) begin
                last_ok  <= rpt_ok;
                last_err <= rpt_err;
            end
            if (count_inc && move_count != '1) begin
                move_count <= move_count + MOVE_CNT_W'(1);
            end
        end
    end

    assign mv_valid     = (state == ISSUE);
    assign busy         = (state != IDLE);
    assign status_pulse = (state == REPORT);

endmodule

// File: tb/tb_solitaire_move_ctrl.sv
// Bench for solitaire_move_ctrl. Directed moves push their expected handshake
// contents and reports into queues; a monitor pops and compares whenever the
// DUT presents a request or a status pulse. A second instance with a 2-bit
// move counter shares all inputs to cover counter saturation.

module tb_solitaire_move_ctrl;

    typedef struct {
        int x;
        int y;
        int d;
    } mv_t;

    typedef struct {
        int ok;
        int err;
        int cnt;
        int cnt2;
    } rpt_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       go_in;
    logic [2:0] piece_x;
    logic [2:0] piece_y;
    logic [1:0] direction;
    logic       game_over;
    logic       mv_ready;
    logic       mv_done;
    logic       mv_legal;

    logic       mv_valid;
    logic [2:0] mv_x;
    logic [2:0] mv_y;
    logic [1:0] mv_dir;
    logic       busy;
    logic       status_pulse;
    logic       last_ok;
    logic [1:0] last_err;
    logic [5:0] move_count;

    logic       b_mv_valid;
    logic [2:0] b_mv_x;
    logic [2:0] b_mv_y;
    logic [1:0] b_mv_dir;
    logic       b_busy;
    logic       b_status_pulse;
    logic       b_last_ok;
    logic [1:0] b_last_err;
    logic [1:0] b_move_count;

    int n_cmp = 0;
    int n_bad = 0;
    int n_pulse = 0;
    int n_rpt_exp = 0;
    int exp_cnt = 0;

    mv_t  mv_q[$];
    rpt_t rpt_q[$];
    mv_t  m;
    rpt_t r;

    solitaire_move_ctrl #(.SYNC_STAGES(2), .TIMEOUT(15), .MOVE_CNT_W(6)) dut (
        .clk(clk), .rst(rst), .go_in(go_in),
        .piece_x(piece_x), .piece_y(piece_y), .direction(direction),
        .game_over(game_over),
        .mv_valid(mv_valid), .mv_x(mv_x), .mv_y(mv_y), .mv_dir(mv_dir),
        .mv_ready(mv_ready), .mv_done(mv_done), .mv_legal(mv_legal),
        .busy(busy), .status_pulse(status_pulse),
        .last_ok(last_ok), .last_err(last_err), .move_count(move_count)
    );

    solitaire_move_ctrl #(.SYNC_STAGES(2), .TIMEOUT(15), .MOVE_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .go_in(go_in),
        .piece_x(piece_x), .piece_y(piece_y), .direction(direction),
        .game_over(game_over),
        .mv_valid(b_mv_valid), .mv_x(b_mv_x), .mv_y(b_mv_y), .mv_dir(b_mv_dir),
        .mv_ready(mv_ready), .mv_done(mv_done), .mv_legal(mv_legal),
        .busy(b_busy), .status_pulse(b_status_pulse),
        .last_ok(b_last_ok), .last_err(b_last_err), .move_count(b_move_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mv(input int x, input int y, input int d);
        mv_t e;
        e.x = x;
        e.y = y;
        e.d = d;
        mv_q.push_back(e);
    endtask

    task automatic push_rpt(input int ok, input int err);
        rpt_t e;
        if (ok != 0) exp_cnt++;
        e.ok   = ok;
        e.err  = err;
        e.cnt  = exp_cnt;
        e.cnt2 = (exp_cnt > 3) ? 3 : exp_cnt;
        rpt_q.push_back(e);
        n_rpt_exp++;
    endtask

    task automatic start_move(input logic [2:0] x, input logic [2:0] y, input logic [1:0] d);
        int n = 0;
        piece_x   = x;
        piece_y   = y;
        direction = d;
        go_in     = 1'b1;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        go_in = 1'b0;
        check("move_started", int'(busy), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("idle_reached", int'(busy), 0);
        repeat (3) tick();
    endtask

    task automatic count_to_report(output int n);
        n = 0;
        while (!status_pulse && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Monitor: compare every accepted request and every report against the queues.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (mv_valid === 1'b1 && mv_ready === 1'b1) begin
                check("request_expected", int'(mv_q.size() != 0), 1);
                if (mv_q.size() != 0) begin
                    m = mv_q.pop_front();
                    check("mv_x", int'(mv_x), m.x);
                    check("mv_y", int'(mv_y), m.y);
                    check("mv_dir", int'(mv_dir), m.d);
                end
            end
            if (status_pulse === 1'b1) begin
                n_pulse++;
                check("report_expected", int'(rpt_q.size() != 0), 1);
                if (rpt_q.size() != 0) begin
                    r = rpt_q.pop_front();
                    check("last_ok", int'(last_ok), r.ok);
                    check("last_err", int'(last_err), r.err);
                    check("move_count", int'(move_count), r.cnt);
                    check("move_count_w2", int'(b_move_count), r.cnt2);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        rst       = 1'b1;
        go_in     = 1'b1;
        piece_x   = '0;
        piece_y   = '0;
        direction = '0;
        game_over = 1'b0;
        mv_ready  = 1'b0;
        mv_done   = 1'b0;
        mv_legal  = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_mv_valid", int'(mv_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_status_pulse", int'(status_pulse), 0);
        check("rst_mv_x", int'(mv_x), 0);
        check("rst_last_ok", int'(last_ok), 0);
        check("rst_last_err", int'(last_err), 0);
        check("rst_move_count", int'(move_count), 0);

        // go held through reset must not produce a move
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("held_go_no_move", int'(busy), 0);
        end
        go_in = 1'b0;
        repeat (3) tick();

        // Legal move 3/1/2, with exact go latency
        mv_ready  = 1'b1;
        piece_x   = 3'd3;
        piece_y   = 3'd1;
        direction = 2'd2;
        push_mv(3, 1, 2);
        push_rpt(1, 0);
        go_in = 1'b1;
        tick();
        tick();
        check("go_latency_early", int'(mv_valid), 0);
        tick();
        check("go_latency", int'(mv_valid), 1);
        go_in = 1'b0;
        tick();
        check("valid_drops_after_accept", int'(mv_valid), 0);
        check("busy_in_wait", int'(busy), 1);
        mv_done  = 1'b1;
        mv_legal = 1'b1;
        tick();
        mv_done = 1'b0;
        tick();
        check("busy_three_cycles", int'(busy), 0);
        wait_idle();

        // Illegal move, verdict one cycle into WAIT
        push_mv(5, 2, 1);
        push_rpt(0, 1);
        start_move(3'd5, 3'd2, 2'd1);
        tick();
        tick();
        mv_done  = 1'b1;
        mv_legal = 1'b0;
        tick();
        mv_done = 1'b0;
        wait_idle();

        // Backpressure: five stalled cycles while piece_x changes
        mv_ready = 1'b0;
        push_mv(6, 4, 3);
        push_rpt(1, 0);
        start_move(3'd6, 3'd4, 2'd3);
        for (int i = 0; i < 5; i++) begin
            piece_x = 3'(i + 1);
            check("bp_valid", int'(mv_valid), 1);
            check("bp_mv_x", int'(mv_x), 6);
            tick();
        end
        check("bp_valid_6th", int'(mv_valid), 1);
        mv_ready = 1'b1;
        tick();
        mv_done  = 1'b1;
        mv_legal = 1'b1;
        tick();
        mv_done = 1'b0;
        wait_idle();

        // Timeout in ISSUE
        mv_ready = 1'b0;
        push_rpt(0, 2);
        start_move(3'd1, 3'd1, 2'd0);
        count_to_report(n);
        check("issue_timeout_cycles", n, 15);
        check("timeout_valid_low", int'(mv_valid), 0);
        wait_idle();

        // Timeout in WAIT
        mv_ready = 1'b1;
        push_mv(2, 3, 1);
        push_rpt(0, 2);
        start_move(3'd2, 3'd3, 2'd1);
        count_to_report(n);
        check("wait_timeout_cycles", n, 15);
        wait_idle();

        // mv_done on the timeout cycle: legal result wins
        push_mv(4, 5, 0);
        push_rpt(1, 0);
        start_move(3'd4, 3'd5, 2'd0);
        repeat (14) tick();
        mv_done  = 1'b1;
        mv_legal = 1'b1;
        tick();
        mv_done = 1'b0;
        check("coincident_report_now", int'(status_pulse), 1);
        wait_idle();

        // Game over: blocked, no request, busy one cycle
        game_over = 1'b1;
        push_rpt(0, 3);
        start_move(3'd7, 3'd7, 2'd3);
        check("blocked_valid_low", int'(mv_valid), 0);
        tick();
        check("blocked_busy_one_cycle", int'(busy), 0);
        game_over = 1'b0;
        repeat (3) tick();

        // Second press during WAIT is dropped
        push_mv(1, 2, 3);
        push_rpt(1, 0);
        start_move(3'd1, 3'd2, 2'd3);
        repeat (4) tick();
        go_in = 1'b1;
        repeat (4) tick();
        go_in = 1'b0;
        mv_done  = 1'b1;
        mv_legal = 1'b1;
        tick();
        mv_done = 1'b0;
        wait_idle();
        check("dropped_go_no_restart", int'(busy), 0);

        // Reset while in WAIT abandons the move
        push_mv(2, 2, 2);
        start_move(3'd2, 3'd2, 2'd2);
        tick();
        rst = 1'b1;
        tick();
        check("rst_wait_busy", int'(busy), 0);
        check("rst_wait_mv_valid", int'(mv_valid), 0);
        check("rst_wait_mv_x", int'(mv_x), 0);
        check("rst_wait_last_ok", int'(last_ok), 0);
        check("rst_wait_last_err", int'(last_err), 0);
        check("rst_wait_move_count", int'(move_count), 0);
        check("rst_wait_move_count_w2", int'(b_move_count), 0);
        rst = 1'b0;
        exp_cnt = 0;
        repeat (4) tick();

        // One legal move after reset counts from zero
        push_mv(6, 1, 1);
        push_rpt(1, 0);
        start_move(3'd6, 3'd1, 2'd1);
        tick();
        mv_done  = 1'b1;
        mv_legal = 1'b1;
        tick();
        mv_done = 1'b0;
        wait_idle();

        check("reports_seen", n_pulse, n_rpt_exp);
        check("mv_queue_drained", mv_q.size(), 0);
        check("rpt_queue_drained", rpt_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
